// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with the PC register, the IF/ID pipeline register
// and a BOOT/RUN/HALT control FSM.
// Optional feature: define FETCH_PERF_CNT_EN to build the fetch_count performance counter.
// Without the macro, fetch_count is tied to zero and no counter register is built.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

   state_e      state;
   logic [31:0] redirect_pc;
   logic [31:0] pc_plus4;
   logic        unused_target_bits;

   // Redirect targets are forced to word alignment.
   assign redirect_pc        = {branch_target[31:2], 2'b00};
   assign unused_target_bits = ^branch_target[1:0];
   // Modulo 2^32 adder; the carry out is dropped.
   assign pc_plus4           = pc + 32'd4;

   // Control FSM together with the PC, IF/ID and halted registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= StBoot;
         pc          <= RESET_PC;
         if_id_pc    <= 32'h0;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         unique case (state)
            StBoot: begin
               // One settling cycle: PC and IF/ID are left untouched.
               state <= StRun;
            end
            StRun: begin
               if (branch_taken) begin
                  pc          <= redirect_pc;
                  if_id_pc    <= pc;
                  if_id_instr <= NOP_INSTR;
                  if_id_valid <= 1'b0;
               end else if (!stall) begin
                  if_id_pc    <= pc;
                  if_id_instr <= instruction;
                  if_id_valid <= 1'b1;
                  if (instruction == EBREAK) begin
                     // Capture the ebreak but park the PC on it.
                     state  <= StHalt;
                     halted <= 1'b1;
                  end else begin
                     pc <= pc_plus4;
                  end
               end
            end
            StHalt: begin
               if (branch_taken) begin
                  pc          <= redirect_pc;
                  if_id_pc    <= pc;
                  if_id_instr <= NOP_INSTR;
                  if_id_valid <= 1'b0;
                  state       <= StRun;
                  halted      <= 1'b0;
               end else begin
                  // Stall is ignored here; IF/ID drains to a bubble.
                  if_id_instr <= NOP_INSTR;
                  if_id_valid <= 1'b0;
               end
            end
            default: begin
               state  <= StBoot;
               halted <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic fetch_fire;

   assign fetch_fire = (state == StRun) && !branch_taken && !stall;

   // Count every normal fetch in RUN, including the ebreak fetch; wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count <= 32'h0;
      end else if (fetch_fire) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`else
   assign fetch_count = 32'h0;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction word placed in IF/ID on flush or bubble.
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port stall, input, 1, hold PC and IF/ID, driven by the downstream hazard unit.
REQ-007 The block SHALL have port branch_taken, input, 1, redirect request from the execute stage.
REQ-008 The block SHALL have port branch_target, input, 32, redirect address.
REQ-009 The block SHALL have port instruction, input, 32, combinational word returned by instruction_memory for pc.
REQ-010 The block SHALL have port pc, output, 32, current fetch address driven to instruction_memory.
REQ-011 The block SHALL have port if_id_pc, output, 32, PC of the captured instruction.
REQ-012 The block SHALL have port if_id_instr, output, 32, captured instruction.
REQ-013 The block SHALL have port if_id_valid, output, 1, IF/ID holds a real instruction.
REQ-014 The block SHALL have port halted, output, 1, high while the FSM is in HALT.
REQ-015 The block SHALL have port fetch_count, output, 32, performance counter (see Configuration).

Function
REQ-016 The FSM SHALL have states BOOT, RUN and HALT, and SHALL enter BOOT on reset.
REQ-017 BOOT SHALL last exactly one cycle with pc held and IF/ID unchanged, then go to RUN unconditionally.
REQ-018 In RUN, the priority SHALL be branch_taken > stall > normal fetch.
REQ-019 RUN with branch_taken SHALL do: pc <= {branch_target[31:2],2'b00}; if_id_instr <= NOP_INSTR; if_id_valid <= 0; if_id_pc <= pc (flush).
REQ-020 RUN with stall and no branch SHALL hold pc, if_id_pc, if_id_instr and if_id_valid unchanged.
REQ-021 RUN with normal fetch SHALL do: if_id_pc <= pc; if_id_instr <= instruction; if_id_valid <= 1; pc <= pc + 4.
REQ-022 The PC adder SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag.
REQ-023 A normal fetch of instruction == 32'h0010_0073 (ebreak) SHALL capture it (valid = 1), hold pc at the ebreak address, and go to HALT.
REQ-024 An ebreak seen during a stall or branch cycle SHALL NOT cause entry to HALT.
REQ-025 HALT with branch_taken SHALL redirect as in REQ-019 and return to RUN.
REQ-026 HALT otherwise SHALL hold pc, and if_id_valid SHALL go to 0 with if_id_instr <= NOP_INSTR one cycle after entry and stay there; stall SHALL be ignored in HALT.
REQ-027 halted SHALL be a registered decode of state == HALT.
REQ-028 Fetch-to-IF/ID latency SHALL be one clock, and the block SHALL hold no combinational path from stall or branch_taken to pc.

Reset
REQ-029 On reset assertion, asynchronously: pc = RESET_PC; if_id_pc = 0; if_id_instr = NOP_INSTR; if_id_valid = 0; halted = 0; fetch_count = 0; state = BOOT.
REQ-030 Reset asserted mid-stall, mid-branch or in HALT SHALL override all other inputs immediately.
REQ-031 Release from reset SHALL take effect on the first rising clk edge after deassertion.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN SHALL control the performance counter.
REQ-033 With FETCH_PERF_CNT_EN defined, fetch_count SHALL increment by 1 on every RUN normal-fetch cycle (REQ-021, including the ebreak fetch) and wrap modulo 2^32.
REQ-034 Without FETCH_PERF_CNT_EN, fetch_count SHALL be tied to 32'h0 and no counter register SHALL be inferred.

Verification
REQ-035 Bench SHALL check reset sequencing: reset pulse then 4 clocks with no stall or branch -> pc sequence 0, 0 (BOOT), 4, 8; if_id_pc = 0 with valid = 1 on the third edge.
REQ-036 Bench SHALL check stall: stall = 1 for 2 cycles at pc = 8 -> pc stays 8, IF/ID stays at pc 4 word, then resumes to 12.
REQ-037 Bench SHALL check branch against stall: branch_taken = 1, target = 32'h0000_0102, stall = 1 -> next pc = 32'h100, if_id_valid = 0, if_id_instr = 32'h13.
REQ-038 Bench SHALL check halt: instruction = 32'h0010_0073 at pc = 32'h24 -> if_id valid ebreak at 32'h24, halted = 1, pc held at 32'h24 for 10 cycles, if_id_valid = 0 after.
REQ-039 Bench SHALL check PC wrap: force redirect to 32'hFFFF_FFFC and run 2 fetches -> pc = 0 then 4.
REQ-040 Bench SHALL check the counter: with FETCH_PERF_CNT_EN, 5 fetches, 2 stalls and 1 branch -> fetch_count = 5; without the macro -> 0.
